// File: rtl/cpu_types_pkg.sv
// Shared CPU-side type definitions: RAM handshake status, arbiter states and requester identity.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IREQ = 2'd1,
        DREQ = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } requester_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the memory arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import cpu_types_pkg::*;

    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              ihit;
    logic              dhit;
    logic [DATA_W-1:0] iload;
    logic [DATA_W-1:0] dload;
    logic              err;
    logic              fault;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    ramstate_t         ramstate;

    // slave: the arbiter itself
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, dhit, iload, dload, err, fault,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    // master: the surrounding datapath and RAM model
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, dhit, iload, dload, err, fault,
        input  ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access, one latched request at a time,
// with alternating priority on contention and a timeout guard against a hung RAM.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state;
    arb_state_t        next_state;
    requester_t        last_grant;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] store_r;
    logic [DATA_W-1:0] iload_r;
    logic [DATA_W-1:0] dload_r;
    logic              wr_r;
    logic              bad_op_r;
    logic              err_r;
    logic              fault_r;
    logic [CNT_W-1:0]  cnt;

    logic i_pend;
    logic d_pend;
    logic grant_data;
    logic in_req;
    logic done_ok;
    logic done_bad;
    logic ram_ren;
    logic ram_wen;

    assign i_pend     = bus.iREN;
    assign d_pend     = bus.dREN | bus.dWEN;
    // On contention the requester that did not win last time goes first.
    assign grant_data = d_pend && (!i_pend || (last_grant == INSTR));
    assign in_req     = (state == IREQ) || (state == DREQ);
    assign done_ok    = (bus.ramstate == ACCESS);
    assign done_bad   = (bus.ramstate == ERROR) || (cnt == CNT_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        case (state)
            IDLE: begin
                if (i_pend || d_pend) begin
                    next_state = grant_data ? DREQ : IREQ;
                end
            end
            IREQ: begin
                ram_ren = 1'b1;
                if (done_ok || done_bad) begin
                    next_state = DONE;
                end
            end
            DREQ: begin
                ram_wen = wr_r;
                ram_ren = !wr_r;
                if (done_ok || done_bad) begin
                    next_state = DONE;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant <= INSTR;
            addr_r     <= '0;
            store_r    <= '0;
            iload_r    <= '0;
            dload_r    <= '0;
            wr_r       <= 1'b0;
            bad_op_r   <= 1'b0;
            err_r      <= 1'b0;
            fault_r    <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    err_r <= 1'b0;
                    if (i_pend || d_pend) begin
                        last_grant <= grant_data ? DATA : INSTR;
                        addr_r     <= grant_data ? bus.daddr : bus.iaddr;
                        store_r    <= grant_data ? bus.dstore : '0;
                        // Read and write together is resolved as a write, flagged at completion.
                        wr_r       <= grant_data && bus.dWEN;
                        bad_op_r   <= grant_data && bus.dREN && bus.dWEN;
                    end
                end
                IREQ, DREQ: begin
                    cnt <= cnt + 1'b1;
                    if (done_ok) begin
                        err_r <= bad_op_r;
                        if (bad_op_r) begin
                            fault_r <= 1'b1;
                        end
                        if (!wr_r) begin
                            if (state == IREQ) begin
                                iload_r <= bus.ramload;
                            end else begin
                                dload_r <= bus.ramload;
                            end
                        end
                    end else if (done_bad) begin
                        err_r   <= 1'b1;
                        fault_r <= 1'b1;
                    end
                end
                DONE: cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = in_req ? addr_r : '0;
    assign bus.ramstore = in_req ? store_r : '0;
    assign bus.ihit     = (state == DONE) && (last_grant == INSTR);
    assign bus.dhit     = (state == DONE) && (last_grant == DATA);
    assign bus.err      = (state == DONE) && err_r;
    assign bus.fault    = fault_r;
    assign bus.iload    = iload_r;
    assign bus.dload    = dload_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, scoreboard of expected completions,
// a vector table of single accesses and hand sequences for contention and mid-access reset.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // RAM model: BUSY for busy_n enabled cycles, then fin_st
  int        ram_cnt;
  int        busy_n = 0;
  ramstate_t fin_st = ACCESS;
  logic [31:0] ram_data = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_cnt <= 0;
    else if (bus.ramREN || bus.ramWEN) ram_cnt <= ram_cnt + 1;
    else ram_cnt <= 0;
  end

  always_comb begin
    bus.ramload = ram_data;
    if (!(bus.ramREN || bus.ramWEN)) bus.ramstate = FREE;
    else if (ram_cnt < busy_n) bus.ramstate = BUSY;
    else bus.ramstate = fin_st;
  end

  typedef struct {
    bit          is_data;
    bit          err;
    int          ren;
    int          wen;
    logic [31:0] addr;
    bit          chk_store;
    logic [31:0] store;
    logic [31:0] iload;
    logic [31:0] dload;
  } exp_t;

  typedef struct {
    bit          is_data;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
    int          busy;
    ramstate_t   fin;
    logic [31:0] load;
    bit          exp_err;
    int          exp_ren;
    int          exp_wen;
  } vec_t;

  exp_t sbq[$];
  logic [31:0] m_iload = '0;
  logic [31:0] m_dload = '0;
  bit          m_fault = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ihit"}, bus.ihit, 0);
    chk({tag, "_dhit"}, bus.dhit, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_fault"}, bus.fault, 0);
    chk({tag, "_iload"}, bus.iload, 0);
    chk({tag, "_dload"}, bus.dload, 0);
    chk({tag, "_ramREN"}, bus.ramREN, 0);
    chk({tag, "_ramWEN"}, bus.ramWEN, 0);
    chk({tag, "_ramaddr"}, bus.ramaddr, 0);
    chk({tag, "_ramstore"}, bus.ramstore, 0);
  endtask

  task automatic wait_hit(input int maxc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (bus.ihit || bus.dhit) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL hit_timeout actual=no_hit required=hit_within_%0d", maxc);
    end
  endtask

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.is_data   = v.is_data;
    e.err       = v.exp_err;
    e.ren       = v.exp_ren;
    e.wen       = v.exp_wen;
    e.addr      = v.addr;
    e.chk_store = v.is_data && v.wr;
    e.store     = v.store;
    if (!v.exp_err && !(v.is_data && v.wr)) begin
      if (v.is_data) m_dload = v.load;
      else m_iload = v.load;
    end
    e.iload = m_iload;
    e.dload = m_dload;
    m_fault = m_fault | v.exp_err;
    return e;
  endfunction

  // Single access: called at a negedge, returns at a negedge one cycle after the hit.
  task automatic apply(input vec_t v);
    bit ok;
    busy_n   = v.busy;
    fin_st   = v.fin;
    ram_data = v.load;
    sbq.push_back(mk_exp(v));
    if (v.is_data) begin
      bus.dREN = v.rd; bus.dWEN = v.wr; bus.daddr = v.addr; bus.dstore = v.store;
    end else begin
      bus.iREN = 1'b1; bus.iaddr = v.addr;
    end
    @(negedge clk);
    // Address and data changes after the grant must not reach the RAM.
    bus.iaddr  = ~v.addr;
    bus.daddr  = ~v.addr;
    bus.dstore = ~v.store;
    wait_hit(100, ok);
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    @(negedge clk);
    chk("fault_after", bus.fault, m_fault);
  endtask

  // Monitor: counts enables per access, checks exclusivity and idle gaps, pops scoreboard on hits
  initial begin
    int ren_c, wen_c, off_c;
    bit seen, cap, prev_hit;
    logic [31:0] a_cap, s_cap;
    exp_t e;
    ren_c = 0; wen_c = 0; off_c = 0; seen = 0; cap = 0; prev_hit = 0;
    a_cap = '0; s_cap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ren_c = 0; wen_c = 0; off_c = 0; seen = 0; cap = 0; prev_hit = 0;
        continue;
      end
      if (bus.ramREN || bus.ramWEN) begin
        chk("ren_wen_exclusive", bus.ramREN & bus.ramWEN, 0);
        if (!cap) begin
          if (seen) chk("idle_gap_ge2", off_c >= 2, 1);
          cap = 1; seen = 1;
        end
        a_cap = bus.ramaddr;
        s_cap = bus.ramstore;
        ren_c += int'(bus.ramREN);
        wen_c += int'(bus.ramWEN);
        off_c = 0;
      end else begin
        off_c++;
      end
      if (bus.ihit || bus.dhit) begin
        chk("hit_single_cycle", prev_hit, 0);
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_hit actual=ihit%0b_dhit%0b required=none", bus.ihit, bus.dhit);
        end else begin
          e = sbq.pop_front();
          chk("ihit", bus.ihit, !e.is_data);
          chk("dhit", bus.dhit, e.is_data);
          chk("err", bus.err, e.err);
          chk("iload", bus.iload, e.iload);
          chk("dload", bus.dload, e.dload);
          chk("ren_cycles", ren_c, e.ren);
          chk("wen_cycles", wen_c, e.wen);
          chk("ramaddr", a_cap, e.addr);
          if (e.chk_store) chk("ramstore", s_cap, e.store);
        end
        ren_c = 0; wen_c = 0; cap = 0;
      end
      prev_hit = bus.ihit || bus.dhit;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    exp_t e;
    bit ok;

    // fields: is_data, rd, wr, addr, store, busy, fin, load, exp_err, exp_ren, exp_wen
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         3,    ACCESS, 32'h8C22_0004, 1'b0, 4,  0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0,    ACCESS, 32'hBAD0_BAD0, 1'b0, 0,  1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0,         2,    ACCESS, 32'h1234_5678, 1'b0, 3,  0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0,         0,    ACCESS, 32'hA5A5_0001, 1'b0, 1,  0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0,         1000, BUSY,   32'hFFFF_FFFF, 1'b1, TO, 0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0,         1,    ERROR,  32'hEEEE_EEEE, 1'b1, 2,  0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0055, 0,    ACCESS, 32'h0000_FFFF, 1'b1, 0,  1};

    // Both requesters held from reset for the contention sequence
    bus.iREN = 1'b1; bus.iaddr = 32'h1000;
    bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = 32'h2000; bus.dstore = 32'h0;
    busy_n = 0; fin_st = ACCESS; ram_data = 32'h0C0F_FEE0;
    repeat (3) @(negedge clk);
    check_zero("reset");

    for (int k = 0; k < 8; k++) begin
      v = '{(k % 2) == 0, 1'b1, 1'b0, ((k % 2) == 0) ? 32'h2000 : 32'h1000, 32'h0,
            0, ACCESS, 32'h0C0F_FEE0, 1'b0, 1, 0};
      sbq.push_back(mk_exp(v));
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_hit(20, ok);
      if (!ok) break;
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    @(negedge clk);
    chk("contention_sb_drained", sbq.size(), 0);

    for (int i = 0; i < 7; i++) begin
      apply(tbl[i]);
    end
    chk("fault_sticky", bus.fault, 1);

    // Reset during the second cycle of a stalled write
    busy_n = 1000; fin_st = BUSY;
    bus.dWEN = 1'b1; bus.daddr = 32'h400; bus.dstore = 32'h77;
    @(negedge clk);
    @(negedge clk);
    chk("midreset_wen_active", bus.ramWEN, 1);
    rst = 1'b1;
    #1;
    check_zero("midreset");
    bus.dWEN = 1'b0;
    sbq.delete();
    m_iload = '0; m_dload = '0; m_fault = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset_idle");
    apply('{1'b0, 1'b1, 1'b0, 32'h0000_0048, 32'h0, 1, ACCESS, 32'h0BAD_F00D, 1'b0, 2, 0});
    chk("final_sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single shared unified RAM port between the instruction-fetch requester (iREN) and the data requester (dREN/dWEN) produced by the CPU control path.
- Sits between the datapath and the RAM model.
- Latches one request at a time and drives the RAM from registered copies.
- Waits on ramstate, then returns a one-cycle hit with registered load data. A timeout guards against a hung RAM.

Parameters:
ADDR_W, 32, width of iaddr/daddr/ramaddr
DATA_W, 32, width of load/store data
TIMEOUT, 16, max cycles waiting for ACCESS before forced error completion (>=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset; one clock; RST is asynchronous, active-high
iREN  in  1  instruction read request, held until ihit
iaddr  in  ADDR_W  instruction address
dREN  in  1  data read request, held until dhit
dWEN  in  1  data write request, held until dhit
daddr  in  ADDR_W  data address
dstore  in  DATA_W  write data
ihit  out  1  one-cycle instruction completion
dhit  out  1  one-cycle data completion
iload  out  DATA_W  registered instruction word
dload  out  DATA_W  registered read data
err  out  1  one-cycle error flag, coincident with ihit/dhit
fault  out  1  sticky error flag, cleared only by RST
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Reset values:
  - state IDLE, last_grant=INSTR.
  - All outputs 0, including fault, iload and dload.
  - Timeout counter 0.
- States:
  - IDLE -> IREQ or DREQ when a request is pending.
  - IREQ/DREQ -> DONE on completion.
  - DONE -> IDLE unconditionally.
- Grant in IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant the one not granted last. After reset data wins first.
  - Grant latches addr, store data and op (read/write) into registers; last_grant is updated.
- IREQ/DREQ:
  - ramaddr and ramstore are driven from the latches.
  - IREQ: ramREN=1.
  - DREQ read: ramREN=1. DREQ write: ramWEN=1.
  - ramREN and ramWEN are never both 1.
  - The counter increments each cycle.
- Completion:
  - ramstate==ACCESS: capture ramload into iload/dload (read only), go to DONE with err=0.
  - ramstate==ERROR, or counter reaching TIMEOUT-1: go to DONE with err=1 and set fault. Load registers are unchanged.
- DONE:
  - The matching hit is 1 for exactly one cycle.
  - ramREN=ramWEN=0, counter cleared.
  - No new grant is made in DONE, so there is a minimum one idle cycle between RAM accesses.
- Latency:
  - Request visible at edge n gives RAM enables from cycle n+1.
  - ACCESS seen at edge m gives hit during cycle m+1.
  - Best case: hit 2 cycles after the request.
- dREN and dWEN both high: treated as a write. err=1 and fault is set on its completion.
- Requester drops its request mid-access: the access still completes (it is not aborted) and the hit pulse is still issued. A requester that dropped its request ignores it.
- Requests are sampled only in IDLE. Address changes during IREQ/DREQ have no effect.
- RST asserted mid-access: immediate return to reset values. The RAM enables drop asynchronously.

Decomposition:
- cpu_types_pkg carries:
  - ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
  - arb_state_t (IDLE, IREQ, DREQ, DONE).
  - requester enum (INSTR, DATA).
- Single flat module; no sub-module needed.

Test Plan:
- Instruction only: iREN=1, iaddr=0x40, RAM gives ACCESS after 3 BUSY cycles with ramload=0x8C220004 -> ramREN high 4 cycles, ihit one cycle later, iload=0x8C220004, err=0.
- Data write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF, dhit single pulse, dload unchanged.
- Contention: iREN and dREN both held from reset, ACCESS immediately each time -> grant order D, I, D, I. There is an idle cycle with no enables between consecutive grants, and no starvation across 8 accesses.
- Timeout: TIMEOUT=16, ramstate stuck BUSY -> ramREN high exactly 16 cycles, then ihit=1 and err=1, fault=1 and remaining 1 until RST.
- RAM ERROR and illegal op: ramstate=ERROR on a dREN access -> dhit with err=1. Then dREN=dWEN=1 -> ramWEN only, err=1 on dhit.
- Reset mid-access: assert RST during DREQ cycle 2 -> ramWEN and ramREN 0 before the next edge, all outputs zero. After release, a new iREN completes normally.
